program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time writer for the unified instruction/data memory that the multicycle CPU reads.
- Takes a byte stream from the UART receiver, assembles big-endian 32-bit words, and writes them to consecutive word addresses from 0.
- Holds the CPU in reset while loading, then releases it.
- Returns an 8-bit checksum byte to the UART transmitter so the host can confirm the load.

Parameters:
- ADDR_W, 12, word-address width of the target memory; capacity is 2**ADDR_W words.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- reload  in  1  one-cycle pulse; honoured only in DONE or ERR; restarts loading
- mem_we  out  1  memory write enable, one cycle per word
- mem_addr  out  ADDR_W  word address (the CPU side uses byte address >> 2)
- mem_wdata  out  32  assembled word
- cpu_rstn  out  1  active-low reset to the CPU core
- tx_valid  out  1  checksum byte available
- tx_data  out  8  checksum byte
- tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both 1
- done  out  1  load complete, CPU running
- err  out  1  header rejected

Behaviour:
- Reset (rstn low, asynchronous):
  - state HDR, byte counter 0, word count 0.
  - mem_addr 0, mem_wdata 0, mem_we 0, checksum 0.
  - cpu_rstn 0, tx_valid 0, tx_data 0, done 0, err 0.
- HDR state:
  - Collects 4 bytes, MSB first, into the 32-bit count N.
  - On the 4th byte with N == 0: go to ACK.
  - On the 4th byte with N > 2**ADDR_W: go to ERR.
  - Otherwise: go to DATA with the remaining-word counter set to N.
- DATA state:
  - Bytes shift into mem_wdata MSB first; every data byte is added into checksum (8-bit sum, wraps mod 256).
  - On the 4th byte of a word, mem_we is 1 in the following cycle. mem_addr and mem_wdata are stable during that cycle.
  - mem_addr increments by 1 in the cycle after mem_we.
  - After the write of word N: go to ACK.
  - Latency: rx_valid of the 4th byte in cycle T -> mem_we in cycle T+1.
  - rx_valid in the same cycle as mem_we is accepted normally as byte 0 of the next word (rx_valid is never dropped).
- ACK state:
  - tx_valid=1, tx_data=checksum; both held stable until tx_ready=1.
  - The handshake cycle moves to DONE; tx_valid=0 from the next cycle.
  - rx bytes arriving in ACK are ignored.
- DONE state:
  - cpu_rstn=1 and done=1, both registered and asserted from the first DONE cycle.
  - rx bytes are ignored.
  - reload -> HDR next cycle; cpu_rstn=0, done=0, checksum=0, mem_addr=0, byte counter 0.
- ERR state:
  - err=1, cpu_rstn stays 0, no memory writes, rx ignored.
  - reload -> HDR, with the same clearing as from DONE.
- mem_we is never asserted outside DATA. mem_addr never exceeds 2**ADDR_W-1; N == 2**ADDR_W fills memory exactly.
- Reset mid-load: immediate return to HDR. Memory contents are not cleared; only the counters are.
- reload asserted outside DONE/ERR: ignored.

Decomposition:
- Shared package: state encoding (HDR, DATA, ACK, DONE, ERR) and the header byte count constant 4.
- One natural sub-module, byte_packer: 4-byte MSB-first shift register, 2-bit byte counter, word_valid strobe. It is used for both header and data words.
- The FSM, address counter and checksum stay in the top module.

Test Plan:
- Load N=2, words 0x3C080005, 0x00000000 (bytes 00 00 00 02 3C 08 00 05 00 00 00 00):
  - mem_we at addr 0 with 0x3C080005, then at addr 1 with 0x00000000.
  - tx_data=0x49 held until tx_ready.
  - cpu_rstn=1 and done=1 after the handshake.
- N=0 (bytes 00 00 00 00):
  - no mem_we; tx_data=0x00; done=1.
- With ADDR_W=2, N=5:
  - err=1, cpu_rstn=0, no mem_we, later bytes ignored.
  - reload -> err=0 and a fresh header is accepted.
- Back-to-back rx_valid every cycle, N=4 with ADDR_W=2:
  - exactly 4 mem_we pulses at addr 0..3, no lost byte; done=1.
- tx_ready held low for 10 cycles in ACK:
  - tx_valid and tx_data stable; done stays 0 until the handshake.
- rstn pulsed low after 6 data bytes:
  - all outputs return to reset values immediately.
  - A subsequent full load writes from addr 0 and the checksum excludes the pre-reset bytes.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types for the boot loader: FSM state encoding and header framing.
// Header and data words both use big-endian byte order.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_ACK,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int HDR_BYTES = 4;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Loader-side bundle: UART rx/tx byte links, reload request, memory write port, CPU control.
// master = the loader, slave = the surrounding system (UART, memory, CPU).
interface program_loader_if #(
    parameter int ADDR_W = 12
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rstn;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              done;
    logic              err;

    modport master (
        input  rx_valid, rx_data, reload, tx_ready,
        output mem_we, mem_addr, mem_wdata, cpu_rstn, tx_valid, tx_data, done, err
    );

    modport slave (
        output rx_valid, rx_data, reload, tx_ready,
        input  mem_we, mem_addr, mem_wdata, cpu_rstn, tx_valid, tx_data, done, err
    );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs bytes MSB-first into 32-bit words; word_vld_o flags the 4th byte combinationally,
// word_q_o holds the completed word from the next cycle. No backpressure: every strobed byte is taken.
module program_loader_byte_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        word_vld_o,
    output logic [31:0] word_o,
    output logic [31:0] word_q_o
);

    logic [1:0]  cnt_q;
    logic [31:0] shift_q;

    assign word_o     = {shift_q[23:0], byte_dat_i};
    assign word_vld_o = byte_vld_i && (cnt_q == 2'(HDR_BYTES - 1));
    assign word_q_o   = shift_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else if (clr_i) begin
            cnt_q <= 2'd0;
        end else if (byte_vld_i) begin
            shift_q <= word_o;
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: header word N, then N big-endian words written from address 0; checksum echoed on tx.
// Latency: 4th byte of a word -> mem_we next cycle. Only tx has backpressure (held until tx_ready).
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic             clk,
    input  logic             rstn,
    program_loader_if.master bus
);

    localparam logic [32:0]       CAP      = 33'(1) << ADDR_W;
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            state_q;
    logic [ADDR_W:0]   rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        csum_q;
    logic              mem_we_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;
    logic              cpu_rstn_q;
    logic              done_q;
    logic              err_q;

    logic              pk_vld;
    logic              pk_clr;
    logic              pk_word_vld;
    logic [31:0]       pk_word;
    logic [31:0]       pk_word_q;

    // Once the last word is in, stray bytes during its write cycle must not reach the packer or checksum.
    assign pk_vld = bus.rx_valid &&
                    ((state_q == ST_HDR) || ((state_q == ST_DATA) && (rem_q != '0)));
    assign pk_clr = bus.reload && ((state_q == ST_DONE) || (state_q == ST_ERR));

    program_loader_byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clr_i      (pk_clr),
        .byte_vld_i (pk_vld),
        .byte_dat_i (bus.rx_data),
        .word_vld_o (pk_word_vld),
        .word_o     (pk_word),
        .word_q_o   (pk_word_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_HDR;
            rem_q      <= '0;
            addr_q     <= '0;
            csum_q     <= 8'd0;
            mem_we_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            cpu_rstn_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                ST_HDR: begin
                    if (pk_word_vld) begin
                        if (pk_word == 32'd0) begin
                            state_q    <= ST_ACK;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= csum_q;
                        end else if ({1'b0, pk_word} > CAP) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_DATA;
                            rem_q   <= pk_word[ADDR_W:0];
                        end
                    end
                end
                ST_DATA: begin
                    if (pk_vld) begin
                        csum_q <= csum_add(csum_q, bus.rx_data);
                    end
                    if (pk_word_vld) begin
                        mem_we_q <= 1'b1;
                        rem_q    <= rem_q - REM_ONE;
                    end
                    // rem_q already counts the word being written, so zero here means it was the last.
                    if (mem_we_q) begin
                        if (rem_q == '0) begin
                            state_q    <= ST_ACK;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= csum_q;
                        end else begin
                            addr_q <= addr_q + ADDR_ONE;
                        end
                    end
                end
                ST_ACK: begin
                    if (bus.tx_ready) begin
                        state_q    <= ST_DONE;
                        tx_valid_q <= 1'b0;
                        cpu_rstn_q <= 1'b1;
                        done_q     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.reload) begin
                        state_q    <= ST_HDR;
                        cpu_rstn_q <= 1'b0;
                        done_q     <= 1'b0;
                        csum_q     <= 8'd0;
                        addr_q     <= '0;
                    end
                end
                ST_ERR: begin
                    if (bus.reload) begin
                        state_q <= ST_HDR;
                        err_q   <= 1'b0;
                        csum_q  <= 8'd0;
                        addr_q  <= '0;
                    end
                end
                default: state_q <= ST_HDR;
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = pk_word_q;
    assign bus.cpu_rstn  = cpu_rstn_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader with ADDR_W=2: expected memory writes queued as bytes are sent,
// checked by a write monitor; each scenario task checks its own handshake and status outputs.
module tb_program_loader;

    localparam int AW = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(AW)) bus();

    program_loader #(.ADDR_W(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    wr_t exp_q[$];
    wr_t mon_e;
    int  total    = 0;
    int  bad      = 0;
    int  we_count = 0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            we_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%h required=no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== {mon_e.addr, mon_e.data}) begin
                    bad++;
                    $display("FAIL mem_write got addr=%0d data=%h required addr=%0d data=%h",
                             bus.mem_addr, bus.mem_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31 - 8 * i -: 8]);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic handshake();
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b0;
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        @(posedge clk);
        #1;
        bus.reload = 1'b0;
    endtask

    task automatic wait_tx(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.tx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.mem_we, bus.cpu_rstn, bus.tx_valid, bus.done, bus.err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got we/cpu/txv/done/err=%b required=00000",
                     {bus.mem_we, bus.cpu_rstn, bus.tx_valid, bus.done, bus.err});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.tx_data} !== '0) begin
            bad++;
            $display("FAIL reset_data got addr=%0d wdata=%h tx=%h required all 0",
                     bus.mem_addr, bus.mem_wdata, bus.tx_data);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_load_n2();
        bit seen;
        exp_q.push_back('{addr: 2'd0, data: 32'h3C080005});
        exp_q.push_back('{addr: 2'd1, data: 32'h00000000});
        send_word(32'd2, 1);
        send_word(32'h3C080005, 1);
        send_word(32'h00000000, 1);
        wait_tx(20, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL n2_tx_timeout tx_valid=%b required=1", bus.tx_valid); end
        total++;
        if (bus.tx_data !== 8'h49) begin bad++; $display("FAIL n2_checksum got=%h required=49", bus.tx_data); end
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({bus.tx_valid, bus.tx_data, bus.done} !== {1'b1, 8'h49, 1'b0}) begin
                bad++;
                $display("FAIL n2_ack_hold got txv=%b tx=%h done=%b required txv=1 tx=49 done=0",
                         bus.tx_valid, bus.tx_data, bus.done);
            end
        end
        handshake();
        @(negedge clk);
        total++;
        if ({bus.done, bus.cpu_rstn, bus.tx_valid} !== 3'b110) begin
            bad++;
            $display("FAIL n2_done got done/cpu/txv=%b required=110", {bus.done, bus.cpu_rstn, bus.tx_valid});
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL n2_writes missing=%0d required=0", exp_q.size()); end
        pulse_reload();
        @(negedge clk);
        total++;
        if ({bus.done, bus.cpu_rstn} !== 2'b00) begin
            bad++;
            $display("FAIL n2_reload got done/cpu=%b required=00", {bus.done, bus.cpu_rstn});
        end
    endtask

    task automatic test_n0();
        bit seen;
        send_word(32'd0, 0);
        wait_tx(10, seen);
        total++;
        if (!seen || bus.tx_data !== 8'h00) begin
            bad++;
            $display("FAIL n0_ack got seen=%b tx=%h required seen=1 tx=00", seen, bus.tx_data);
        end
        handshake();
        @(negedge clk);
        total++;
        if ({bus.done, bus.cpu_rstn} !== 2'b11) begin
            bad++;
            $display("FAIL n0_done got done/cpu=%b required=11", {bus.done, bus.cpu_rstn});
        end
        pulse_reload();
    endtask

    task automatic test_err();
        bit seen;
        send_word(32'd5, 1);
        @(negedge clk);
        total++;
        if ({bus.err, bus.cpu_rstn, bus.done} !== 3'b100) begin
            bad++;
            $display("FAIL err_enter got err/cpu/done=%b required=100", {bus.err, bus.cpu_rstn, bus.done});
        end
        send_word(32'hAABBCCDD, 0);
        @(negedge clk);
        total++;
        if ({bus.err, bus.tx_valid} !== 2'b10) begin
            bad++;
            $display("FAIL err_ignore got err/txv=%b required=10", {bus.err, bus.tx_valid});
        end
        pulse_reload();
        @(negedge clk);
        total++;
        if (bus.err !== 1'b0) begin bad++; $display("FAIL err_reload got err=%b required=0", bus.err); end
        exp_q.push_back('{addr: 2'd0, data: 32'hDEADBEEF});
        send_word(32'd1, 0);
        send_word(32'hDEADBEEF, 0);
        wait_tx(10, seen);
        total++;
        if (!seen || bus.tx_data !== 8'h38) begin
            bad++;
            $display("FAIL err_fresh_ack got seen=%b tx=%h required seen=1 tx=38", seen, bus.tx_data);
        end
        handshake();
        @(negedge clk);
        total++;
        if (bus.done !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL err_fresh_done got done=%b pending=%0d required done=1 pending=0", bus.done, exp_q.size());
        end
        pulse_reload();
    endtask

    task automatic test_back_to_back();
        bit seen;
        int we_start;
        we_start = we_count;
        exp_q.push_back('{addr: 2'd0, data: 32'h11223344});
        exp_q.push_back('{addr: 2'd1, data: 32'h55667788});
        exp_q.push_back('{addr: 2'd2, data: 32'h99AABBCC});
        exp_q.push_back('{addr: 2'd3, data: 32'hDDEEFF00});
        send_word(32'd4, 0);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        send_word(32'h99AABBCC, 0);
        send_word(32'hDDEEFF00, 0);
        wait_tx(10, seen);
        total++;
        if (!seen || bus.tx_data !== 8'hF8 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ack got seen=%b tx=%h err=%b required seen=1 tx=f8 err=0", seen, bus.tx_data, bus.err);
        end
        handshake();
        @(negedge clk);
        total++;
        if (we_count - we_start != 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_writes got count=%0d pending=%0d required count=4 pending=0",
                     we_count - we_start, exp_q.size());
        end
        total++;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b required=1", bus.done); end
        pulse_reload();
    endtask

    task automatic test_tx_stall();
        bit seen;
        exp_q.push_back('{addr: 2'd0, data: 32'h01020304});
        send_word(32'd1, 1);
        send_word(32'h01020304, 1);
        wait_tx(10, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL stall_tx_timeout tx_valid=%b required=1", bus.tx_valid); end
        pulse_reload();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({bus.tx_valid, bus.tx_data, bus.done} !== {1'b1, 8'h0A, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold cycle=%0d got txv=%b tx=%h done=%b required txv=1 tx=0a done=0",
                         i, bus.tx_valid, bus.tx_data, bus.done);
            end
        end
        handshake();
        @(negedge clk);
        total++;
        if ({bus.done, bus.tx_valid} !== 2'b10) begin
            bad++;
            $display("FAIL stall_done got done/txv=%b required=10", {bus.done, bus.tx_valid});
        end
        pulse_reload();
    endtask

    task automatic test_reset_mid();
        bit seen;
        exp_q.push_back('{addr: 2'd0, data: 32'hAABBCCDD});
        send_word(32'd2, 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
        send_byte(8'hFF);
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({bus.mem_we, bus.cpu_rstn, bus.tx_valid, bus.done, bus.err, bus.tx_data} !== '0) begin
            bad++;
            $display("FAIL midrst_flags got we/cpu/txv/done/err=%b tx=%h required all 0",
                     {bus.mem_we, bus.cpu_rstn, bus.tx_valid, bus.done, bus.err}, bus.tx_data);
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata} !== '0) begin
            bad++;
            $display("FAIL midrst_data got addr=%0d wdata=%h required addr=0 wdata=0", bus.mem_addr, bus.mem_wdata);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_first_word pending=%0d required=0", exp_q.size()); end
        @(negedge clk);
        rstn = 1'b1;
        exp_q.push_back('{addr: 2'd0, data: 32'h10203040});
        send_word(32'd1, 0);
        send_word(32'h10203040, 0);
        wait_tx(10, seen);
        total++;
        if (!seen || bus.tx_data !== 8'hA0) begin
            bad++;
            $display("FAIL midrst_reload_ack got seen=%b tx=%h required seen=1 tx=a0", seen, bus.tx_data);
        end
        handshake();
        @(negedge clk);
        total++;
        if (bus.done !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL midrst_done got done=%b pending=%0d required done=1 pending=0", bus.done, exp_q.size());
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.reload   = 1'b0;
        bus.tx_ready = 1'b0;
        test_reset();
        test_load_n2();
        test_n0();
        test_err();
        test_back_to_back();
        test_tx_stall();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
